// File: rtl/mos6502_irq_controller.sv
// Prioritised, synchronised IRQ aggregator for a 6502-style core with per-channel edge/level triggering.
// Define IRQ_OVERRUN_EN to build the sticky per-channel lost-edge (OVERRUN) flags; otherwise OVERRUN is tied low.
module mos6502_irq_controller #(
  parameter int               NCH         = 4,
  parameter logic [NCH-1:0]   EDGE_MASK   = {NCH{1'b1}},
  parameter int               SYNC_STAGES = 2,
  parameter int               IDW         = 3
) (
  input  logic           clk,
  input  logic           RESET,
  input  logic           clk_en,
  input  logic [NCH-1:0] nIN,
  input  logic [NCH-1:0] ENABLE,
  input  logic           T0,
  input  logic           NEXT_T,
  input  logic           I_mask,
  input  logic           ACK,
  input  logic [IDW-1:0] ACK_ID,
  output logic           nIRQ_T0,
  output logic           nIRQ_req,
  output logic [IDW-1:0] IRQ_ID,
  output logic [NCH-1:0] PENDING,
  output logic [NCH-1:0] OVERRUN
);

  logic [NCH-1:0]       sync_q [SYNC_STAGES];
  logic [NCH-1:0]       sync_in;
  logic [NCH-1:0]       prev_q;
  logic [SYNC_STAGES:0] arm_q;
  logic                 armed;
  logic [NCH-1:0]       fall;
  logic [NCH-1:0]       ack_hit;
  logic [NCH-1:0]       pend_q;
  logic [NCH-1:0]       active;
  logic                 any_active;
  logic [IDW-1:0]       win_id;
  logic                 nirq_t0_q;
  logic                 nirq_req_q;
  logic [IDW-1:0]       irq_id_q;
  logic                 unused_next_t;

  assign unused_next_t = NEXT_T;

  always_ff @(posedge clk) begin
    if (RESET) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '1;
      prev_q <= '1;
      arm_q  <= '0;
    end else begin
      sync_q[0] <= nIN;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      prev_q <= sync_in;
      arm_q  <= {arm_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  // The chain restarts at all-ones, so edges stay masked until a real prev/current pair has flushed through.
  assign sync_in = sync_q[SYNC_STAGES-1];
  assign armed   = arm_q[SYNC_STAGES];
  assign fall    = prev_q & ~sync_in & {NCH{armed}} & EDGE_MASK;

  always_comb begin
    ack_hit = '0;
    for (int i = 0; i < NCH; i++)
      ack_hit[i] = clk_en & ACK & (ACK_ID == IDW'(i));
  end

  always_ff @(posedge clk) begin
    if (RESET) pend_q <= '0;
    else       pend_q <= fall | (pend_q & ~ack_hit);
  end

  assign PENDING = (pend_q & EDGE_MASK) | (~sync_in & ~EDGE_MASK);

`ifdef IRQ_OVERRUN_EN
  logic [NCH-1:0] ovr_q;

  always_ff @(posedge clk) begin
    if (RESET) ovr_q <= '0;
    else       ovr_q <= (fall & pend_q & ~ack_hit) | (ovr_q & ~ack_hit);
  end

  assign OVERRUN = ovr_q;
`else
  assign OVERRUN = '0;
`endif

  assign active     = PENDING & ENABLE;
  assign any_active = |active;

  // Scan from the lowest priority upward so channel 0 is written last and wins.
  always_comb begin
    win_id = '0;
    for (int i = NCH - 1; i >= 0; i--)
      if (active[i]) win_id = IDW'(i);
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      nirq_t0_q  <= 1'b1;
      nirq_req_q <= 1'b1;
      irq_id_q   <= '0;
    end else if (clk_en) begin
      if (!T0) begin
        nirq_t0_q <= ~any_active | I_mask;
      end else begin
        nirq_req_q <= nirq_t0_q;
        irq_id_q   <= win_id;
      end
    end
  end

  assign nIRQ_T0  = nirq_t0_q;
  assign nIRQ_req = nirq_req_q;
  assign IRQ_ID   = irq_id_q;

endmodule

// File: tb/tb_mos6502_irq_controller.sv
// Bench for mos6502_irq_controller: an all-edge instance and a channel-0-level instance share stimulus;
// expected outputs are queued as each step is driven and compared one clock later.
`timescale 1ns/1ps
module tb_mos6502_irq_controller;

  localparam int NCH = 4;
  localparam int IDW = 3;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;
  localparam logic [3:0] F4 = 4'hF;
  localparam logic [3:0] Z4 = 4'h0;
`ifdef IRQ_OVERRUN_EN
  localparam logic [3:0] OVR_EXP = 4'b0100;
`else
  localparam logic [3:0] OVR_EXP = 4'b0000;
`endif

  typedef struct packed {
    logic       rst;
    logic       ce;
    logic       t0;
    logic       im;
    logic [3:0] nin;
    logic [3:0] en;
    logic       ack;
    logic [2:0] aid;
    logic [3:0] pend;
    logic       t0o;
    logic       req;
    logic [2:0] id;
    logic [3:0] ovr;
    logic       chk_l;
    logic [3:0] lpend;
    logic       lreq;
  } vec_t;

  logic           clk;
  logic           RESET;
  logic           clk_en;
  logic [NCH-1:0] nIN;
  logic [NCH-1:0] ENABLE;
  logic           T0;
  logic           NEXT_T;
  logic           I_mask;
  logic           ACK;
  logic [IDW-1:0] ACK_ID;

  logic           nIRQ_T0;
  logic           nIRQ_req;
  logic [IDW-1:0] IRQ_ID;
  logic [NCH-1:0] PENDING;
  logic [NCH-1:0] OVERRUN;

  logic           unused_l_t0;
  logic           l_req;
  logic [IDW-1:0] unused_l_id;
  logic [NCH-1:0] l_pend;
  logic [NCH-1:0] unused_l_ovr;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  mos6502_irq_controller #(.NCH(4), .EDGE_MASK(4'b1111), .SYNC_STAGES(2), .IDW(3)) dut (
    .clk(clk), .RESET(RESET), .clk_en(clk_en), .nIN(nIN), .ENABLE(ENABLE), .T0(T0),
    .NEXT_T(NEXT_T), .I_mask(I_mask), .ACK(ACK), .ACK_ID(ACK_ID),
    .nIRQ_T0(nIRQ_T0), .nIRQ_req(nIRQ_req), .IRQ_ID(IRQ_ID), .PENDING(PENDING), .OVERRUN(OVERRUN)
  );

  mos6502_irq_controller #(.NCH(4), .EDGE_MASK(4'b1110), .SYNC_STAGES(2), .IDW(3)) dut_l (
    .clk(clk), .RESET(RESET), .clk_en(clk_en), .nIN(nIN), .ENABLE(ENABLE), .T0(T0),
    .NEXT_T(NEXT_T), .I_mask(I_mask), .ACK(ACK), .ACK_ID(ACK_ID),
    .nIRQ_T0(unused_l_t0), .nIRQ_req(l_req), .IRQ_ID(unused_l_id), .PENDING(l_pend),
    .OVERRUN(unused_l_ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input logic rst, input logic ce, input logic t0, input logic im,
                              input logic [3:0] nin, input logic [3:0] en,
                              input logic ack, input logic [2:0] aid,
                              input logic [3:0] pend, input logic t0o, input logic req,
                              input logic [2:0] id, input logic [3:0] ovr,
                              input logic chk_l, input logic [3:0] lpend, input logic lreq);
    vec_t v;
    v.rst = rst; v.ce = ce; v.t0 = t0; v.im = im; v.nin = nin; v.en = en;
    v.ack = ack; v.aid = aid; v.pend = pend; v.t0o = t0o; v.req = req; v.id = id;
    v.ovr = ovr; v.chk_l = chk_l; v.lpend = lpend; v.lreq = lreq;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    RESET  = v.rst;
    clk_en = v.ce;
    T0     = v.t0;
    I_mask = v.im;
    nIN    = v.nin;
    ENABLE = v.en;
    ACK    = v.ack;
    ACK_ID = v.aid;
    NEXT_T = 1'($urandom_range(0, 1));
    exp_q.push_back(v);
  endtask

  task automatic cmp(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s step %0d: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic checkOutput(input int idx);
    vec_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL scoreboard step %0d: got empty queue, expected an entry", idx);
    end else begin
      e = exp_q.pop_front();
      cmp("PENDING",  idx, {4'b0, PENDING},  {4'b0, e.pend});
      cmp("nIRQ_T0",  idx, {7'b0, nIRQ_T0},  {7'b0, e.t0o});
      cmp("nIRQ_req", idx, {7'b0, nIRQ_req}, {7'b0, e.req});
      cmp("IRQ_ID",   idx, {5'b0, IRQ_ID},   {5'b0, e.id});
      cmp("OVERRUN",  idx, {4'b0, OVERRUN},  {4'b0, e.ovr});
      if (e.chk_l) begin
        cmp("lvl_PENDING",  idx, {4'b0, l_pend}, {4'b0, e.lpend});
        cmp("lvl_nIRQ_req", idx, {7'b0, l_req},  {7'b0, e.lreq});
      end
    end
  endtask

  task automatic runStep(input vec_t v, input int idx);
    applyStimulus(v);
    @(posedge clk);
    #1;
    checkOutput(idx);
  endtask

  initial begin
    // reset, then a one-cycle pulse on channel 2 carried to an interrupt request
    vecs.push_back(mk(H,L,L,L, F4,F4, L,3'd0, Z4,H,H,3'd0,Z4, L,Z4,H));
    vecs.push_back(mk(H,L,L,L, F4,F4, L,3'd0, Z4,H,H,3'd0,Z4, L,Z4,H));
    vecs.push_back(mk(L,L,L,L, F4,F4, L,3'd0, Z4,H,H,3'd0,Z4, L,Z4,H));
    vecs.push_back(mk(L,L,L,L, F4,F4, L,3'd0, Z4,H,H,3'd0,Z4, L,Z4,H));
    vecs.push_back(mk(L,L,L,L, 4'b1011,F4, L,3'd0, Z4,H,H,3'd0,Z4, L,Z4,H));
    vecs.push_back(mk(L,L,L,L, F4,F4, L,3'd0, Z4,H,H,3'd0,Z4, L,Z4,H));
    vecs.push_back(mk(L,L,L,L, F4,F4, L,3'd0, 4'b0100,H,H,3'd0,Z4, L,Z4,H));
    vecs.push_back(mk(L,H,L,L, F4,F4, L,3'd0, 4'b0100,L,H,3'd0,Z4, L,Z4,H));
    vecs.push_back(mk(L,H,H,L, F4,F4, L,3'd0, 4'b0100,L,L,3'd2,Z4, L,Z4,H));
    vecs.push_back(mk(L,H,L,L, F4,F4, H,3'd2, Z4,L,L,3'd2,Z4, L,Z4,H));
    vecs.push_back(mk(L,H,L,L, F4,F4, L,3'd0, Z4,H,L,3'd2,Z4, L,Z4,H));
    vecs.push_back(mk(L,H,H,L, F4,F4, L,3'd0, Z4,H,H,3'd0,Z4, L,Z4,H));
    vecs.push_back(mk(L,L,H,L, F4,F4, L,3'd0, Z4,H,H,3'd0,Z4, L,Z4,H));
    // simultaneous edges on channels 1 and 3, priority and acknowledge
    vecs.push_back(mk(L,L,L,L, 4'b0101,F4, L,3'd0, Z4,H,H,3'd0,Z4, L,Z4,H));
    vecs.push_back(mk(L,L,L,L, 4'b0101,F4, L,3'd0, Z4,H,H,3'd0,Z4, L,Z4,H));
    vecs.push_back(mk(L,L,L,L, F4,F4, L,3'd0, 4'b1010,H,H,3'd0,Z4, L,Z4,H));
    vecs.push_back(mk(L,H,L,L, F4,F4, L,3'd0, 4'b1010,L,H,3'd0,Z4, L,Z4,H));
    vecs.push_back(mk(L,H,H,L, F4,F4, L,3'd0, 4'b1010,L,L,3'd1,Z4, L,Z4,H));
    vecs.push_back(mk(L,H,L,L, F4,F4, H,3'd1, 4'b1000,L,L,3'd1,Z4, L,Z4,H));
    vecs.push_back(mk(L,H,H,L, F4,F4, L,3'd0, 4'b1000,L,L,3'd3,Z4, L,Z4,H));
    vecs.push_back(mk(L,H,L,L, F4,F4, H,3'd3, Z4,L,L,3'd3,Z4, L,Z4,H));
    vecs.push_back(mk(L,H,L,L, F4,F4, L,3'd0, Z4,H,L,3'd3,Z4, L,Z4,H));
    vecs.push_back(mk(L,H,H,L, F4,F4, L,3'd0, Z4,H,H,3'd0,Z4, L,Z4,H));
    // I_mask, gated and out-of-range ACK, ENABLE withdrawal; level instance sees a short pulse
    vecs.push_back(mk(L,L,L,L, 4'b1110,F4, L,3'd0, Z4,H,H,3'd0,Z4, H,Z4,H));
    vecs.push_back(mk(L,L,L,L, F4,F4, L,3'd0, Z4,H,H,3'd0,Z4, H,4'b0001,H));
    vecs.push_back(mk(L,L,L,L, F4,F4, L,3'd0, 4'b0001,H,H,3'd0,Z4, H,Z4,H));
    vecs.push_back(mk(L,H,L,H, F4,F4, L,3'd0, 4'b0001,H,H,3'd0,Z4, H,Z4,H));
    vecs.push_back(mk(L,H,H,H, F4,F4, L,3'd0, 4'b0001,H,H,3'd0,Z4, H,Z4,H));
    vecs.push_back(mk(L,L,L,L, F4,F4, H,3'd0, 4'b0001,H,H,3'd0,Z4, H,Z4,H));
    vecs.push_back(mk(L,H,L,L, F4,F4, H,3'd7, 4'b0001,L,H,3'd0,Z4, H,Z4,H));
    vecs.push_back(mk(L,H,H,L, F4,F4, L,3'd0, 4'b0001,L,L,3'd0,Z4, H,Z4,H));
    vecs.push_back(mk(L,H,L,L, F4,4'b1110, L,3'd0, 4'b0001,H,L,3'd0,Z4, H,Z4,H));
    vecs.push_back(mk(L,H,H,L, F4,4'b1110, L,3'd0, 4'b0001,H,H,3'd0,Z4, H,Z4,H));
    vecs.push_back(mk(L,H,H,L, F4,F4, H,3'd0, Z4,H,H,3'd0,Z4, H,Z4,H));
    // level channel released before the sample point, then ACK against a held level
    vecs.push_back(mk(L,L,L,L, 4'b1110,F4, L,3'd0, Z4,H,H,3'd0,Z4, H,Z4,H));
    vecs.push_back(mk(L,L,L,L, 4'b1110,F4, L,3'd0, Z4,H,H,3'd0,Z4, H,4'b0001,H));
    vecs.push_back(mk(L,L,L,L, F4,F4, L,3'd0, 4'b0001,H,H,3'd0,Z4, H,4'b0001,H));
    vecs.push_back(mk(L,L,L,L, F4,F4, L,3'd0, 4'b0001,H,H,3'd0,Z4, H,Z4,H));
    vecs.push_back(mk(L,H,L,L, F4,F4, L,3'd0, 4'b0001,L,H,3'd0,Z4, H,Z4,H));
    vecs.push_back(mk(L,H,H,L, F4,F4, L,3'd0, 4'b0001,L,L,3'd0,Z4, H,Z4,H));
    vecs.push_back(mk(L,H,L,L, F4,F4, H,3'd0, Z4,L,L,3'd0,Z4, H,Z4,H));
    vecs.push_back(mk(L,L,L,L, 4'b1110,F4, L,3'd0, Z4,L,L,3'd0,Z4, H,Z4,H));
    vecs.push_back(mk(L,L,L,L, 4'b1110,F4, L,3'd0, Z4,L,L,3'd0,Z4, H,4'b0001,H));
    vecs.push_back(mk(L,H,L,L, 4'b1110,F4, H,3'd0, 4'b0001,H,L,3'd0,Z4, H,4'b0001,H));
    vecs.push_back(mk(L,H,H,L, F4,F4, L,3'd0, 4'b0001,H,H,3'd0,Z4, H,4'b0001,L));
    vecs.push_back(mk(L,L,L,L, F4,F4, L,3'd0, 4'b0001,H,H,3'd0,Z4, H,Z4,L));
    vecs.push_back(mk(L,H,H,L, F4,F4, H,3'd0, Z4,H,H,3'd0,Z4, H,Z4,L));
    // double edge on channel 2 without ACK, then an edge coincident with its ACK
    vecs.push_back(mk(L,L,L,L, 4'b1011,F4, L,3'd0, Z4,H,H,3'd0,Z4, L,Z4,H));
    vecs.push_back(mk(L,L,L,L, F4,F4, L,3'd0, Z4,H,H,3'd0,Z4, L,Z4,H));
    vecs.push_back(mk(L,L,L,L, F4,F4, L,3'd0, 4'b0100,H,H,3'd0,Z4, L,Z4,H));
    vecs.push_back(mk(L,L,L,L, 4'b1011,F4, L,3'd0, 4'b0100,H,H,3'd0,Z4, L,Z4,H));
    vecs.push_back(mk(L,L,L,L, F4,F4, L,3'd0, 4'b0100,H,H,3'd0,Z4, L,Z4,H));
    vecs.push_back(mk(L,L,L,L, F4,F4, L,3'd0, 4'b0100,H,H,3'd0,OVR_EXP, L,Z4,H));
    vecs.push_back(mk(L,L,L,L, 4'b1011,F4, L,3'd0, 4'b0100,H,H,3'd0,OVR_EXP, L,Z4,H));
    vecs.push_back(mk(L,L,L,L, F4,F4, L,3'd0, 4'b0100,H,H,3'd0,OVR_EXP, L,Z4,H));
    vecs.push_back(mk(L,H,L,L, F4,F4, H,3'd2, 4'b0100,L,H,3'd0,Z4, L,Z4,H));
    vecs.push_back(mk(L,H,L,L, F4,F4, H,3'd2, Z4,L,H,3'd0,Z4, L,Z4,H));

    $display("[TB] applying %0d table vectors", vecs.size());
    foreach (vecs[i]) runStep(vecs[i], i);

    // reset in the middle of an asserted request, with channel 0 held low through reset release
    runStep(mk(L,L,L,L, 4'b1110,F4, L,3'd0, Z4,L,H,3'd0,Z4, H,Z4,L), 57);
    runStep(mk(L,L,L,L, 4'b1110,F4, L,3'd0, Z4,L,H,3'd0,Z4, H,4'b0001,L), 58);
    runStep(mk(L,H,L,L, 4'b1110,F4, L,3'd0, 4'b0001,H,H,3'd0,Z4, H,4'b0001,L), 59);
    runStep(mk(L,H,L,L, 4'b1110,F4, L,3'd0, 4'b0001,L,H,3'd0,Z4, H,4'b0001,L), 60);
    runStep(mk(L,H,H,L, 4'b1110,F4, L,3'd0, 4'b0001,L,L,3'd0,Z4, H,4'b0001,L), 61);
    runStep(mk(H,H,H,L, 4'b1110,F4, L,3'd0, Z4,H,H,3'd0,Z4, H,Z4,H), 62);
    runStep(mk(H,H,H,L, 4'b1110,F4, H,3'd0, Z4,H,H,3'd0,Z4, H,Z4,H), 63);
    runStep(mk(L,L,L,L, 4'b1110,F4, L,3'd0, Z4,H,H,3'd0,Z4, H,Z4,H), 64);
    for (int k = 65; k <= 70; k++)
      runStep(mk(L,L,L,L, 4'b1110,F4, L,3'd0, Z4,H,H,3'd0,Z4, H,4'b0001,H), k);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mos6502_irq_controller.md
MOS6502_IRQ_CONTROLLER -- requirements
Module: mos6502_irq_controller

Interface
REQ-001 Parameter NCH, default 4, shall set the number of interrupt channels (legal range 1..8).
REQ-002 Parameter EDGE_MASK, default {NCH{1'b1}}, shall select the trigger type per channel: bit=1 falling-edge latched, bit=0 low-level.
REQ-003 Parameter SYNC_STAGES, default 2, shall set the input synchroniser depth (legal range 1..3).
REQ-004 Parameter IDW, default 3, shall set the width of channel-index ports (IDW >= clog2(NCH), minimum 1).
REQ-005 clk  in  1  single system clock; all state changes on its rising edge.
REQ-006 RESET  in  1  synchronous, active-high reset.
REQ-007 clk_en  in  1  CPU phase enable; qualifies all CPU-side updates.
REQ-008 nIN  in  NCH  active-low asynchronous interrupt request lines.
REQ-009 ENABLE  in  NCH  per-channel enable; 0 hides the channel from arbitration without clearing its pending state.
REQ-010 T0  in  1  CPU is in the last cycle of an instruction.
REQ-011 NEXT_T  in  1  CPU timing-state advance strobe.
REQ-012 I_mask  in  1  CPU I flag; 1 suppresses all requests.
REQ-013 ACK  in  1  interrupt-acknowledge strobe from the vector-fetch sequence.
REQ-014 ACK_ID  in  IDW  channel index being acknowledged.
REQ-015 nIRQ_T0  out  1  request sampled before T0, active-low.
REQ-016 nIRQ_req  out  1  request committed at T0, active-low; the CPU branches to the interrupt sequence on 0.
REQ-017 IRQ_ID  out  IDW  index of the winning channel, valid while nIRQ_req=0.
REQ-018 PENDING  out  NCH  raw pending vector, before ENABLE is applied.
REQ-019 OVERRUN  out  NCH  sticky per-channel lost-edge flags (see Configuration).

Function
REQ-020 Each nIN bit shall pass through a SYNC_STAGES-deep flop chain clocked every clk, not gated by clk_en.
REQ-021 Edge channels shall set PENDING on any clk cycle where the synchronised input is 0 and its previous synchronised value was 1; pulses of 1 synchronised cycle or longer shall not be lost.
REQ-022 An edge channel shall clear PENDING only when clk_en=1, ACK=1 and ACK_ID equals the channel index.
REQ-023 If a set (edge) and a clear (ACK) hit the same channel in the same cycle, the set shall win and PENDING shall remain 1.
REQ-024 For a level channel, PENDING shall equal the inverted synchronised input; ACK shall have no effect on it.
REQ-025 ACK with ACK_ID >= NCH shall be ignored.
REQ-026 ACTIVE shall be defined as PENDING & ENABLE; ANY shall be defined as the OR-reduction of ACTIVE.
REQ-027 When clk_en=1 and T0=0, nIRQ_T0 shall load ~ANY | I_mask.
REQ-028 When clk_en=1 and T0=1, nIRQ_req shall load nIRQ_T0 (one-instruction-boundary latency), and IRQ_ID shall load the lowest-index set bit of ACTIVE; if ACTIVE is 0, IRQ_ID shall load 0.
REQ-029 nIRQ_T0 and nIRQ_req shall hold when clk_en=0; IRQ_ID shall change only together with a nIRQ_req load.
REQ-030 Fixed priority shall apply: channel 0 is the highest priority, channel NCH-1 the lowest.
REQ-031 A request withdrawn, by ENABLE, I_mask or level release, before the T0 sample shall not assert nIRQ_req.
REQ-032 NEXT_T shall have no effect on channel state; it is reserved for the NMI extension and shall be decoded as T0 & ~NEXT_T only when NMI_EN is defined (out of scope here).

Reset
REQ-033 While RESET=1 on a clk edge: synchroniser flops shall load 1, PENDING 0, OVERRUN 0, nIRQ_T0 1, nIRQ_req 1, IRQ_ID 0.
REQ-034 RESET shall override clk_en and any simultaneous edge or ACK.
REQ-035 The first cycle after RESET deasserts shall not detect an edge on an input that is already low.

Configuration
REQ-036 Macro IRQ_OVERRUN_EN defined: OVERRUN[i] shall set when an edge is detected on edge channel i while PENDING[i]=1 and no same-cycle clear occurs, and shall clear on a valid ACK of channel i (set wins on a tie).
REQ-037 Macro IRQ_OVERRUN_EN undefined: OVERRUN shall be constant 0 and no overrun logic shall be synthesised.

Verification
REQ-038 NCH=4, EDGE_MASK=4'b1111: 1-clk low pulse on nIN[2] with clk_en=0 -> PENDING=4'b0100; after next ~T0 then T0 clk_en cycles -> nIRQ_req=0, IRQ_ID=2.
REQ-039 nIN[1] and nIN[3] fall in the same cycle -> IRQ_ID=1; ACK with ACK_ID=1 -> PENDING=4'b1000; next boundary -> IRQ_ID=3.
REQ-040 I_mask=1 with PENDING=4'b0001 -> nIRQ_req stays 1; I_mask=0 -> nIRQ_req=0 within one ~T0/T0 pair.
REQ-041 EDGE_MASK=4'b1110, nIN[0] held low then released before the ~T0 sample -> nIRQ_req stays 1; ACK_ID=0 -> no change.
REQ-042 IRQ_OVERRUN_EN defined: two falling edges on nIN[2] without an ACK -> OVERRUN=4'b0100; edge coincident with ACK_ID=2 -> PENDING[2]=1; undefined -> OVERRUN=0.
REQ-043 RESET=1 mid-request with nIRQ_req=0 -> next clk: nIRQ_req=1, PENDING=0; hold nIN[0]=0 through reset release -> no PENDING set.
